// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad column debouncer.
package keypad_pkg;

    localparam int COL_W = 4;
    localparam logic [COL_W-1:0] NO_KEY = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

    function automatic logic is_onehot(input logic [COL_W-1:0] v);
        return (v != NO_KEY) && ((v & (v - 1'b1)) == NO_KEY);
    endfunction

endpackage

// File: rtl/sync_nff.sv
// Multi-flop synchroniser; flops reset to all-ones so an idle pulled-up bus reads as released.
module sync_nff #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stages <= '1;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/keypad_col_debounce.sv
// Synchronises and debounces active-low keypad columns into an active-high one-hot vector.
module keypad_col_debounce
    import keypad_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [COL_W-1:0] col_raw,
    input  logic [COL_W-1:0] r_sel,
    output logic [COL_W-1:0] col_sync,
    output logic             key_held,
    output logic             press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

    logic [COL_W-1:0] raw_q;
    logic [COL_W-1:0] s;
    logic [COL_W-1:0] r_q;
    logic             row_changed;

    debounce_state_t  state, state_n;
    logic [COL_W-1:0] cap, cap_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [COL_W-1:0] col_n;
    logic             pulse_n;

    sync_nff #(
        .WIDTH(COL_W),
        .DEPTH(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (col_raw),
        .q    (raw_q)
    );

    assign s           = ~raw_q;
    assign row_changed = (r_sel != r_q);
    assign cnt_inc     = (cnt == CNT_SAT) ? cnt : cnt + 1'b1;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cap_n   = cap;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (is_onehot(s)) begin
                    cap_n   = s;
                    cnt_n   = '0;
                    state_n = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (s != cap || row_changed) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_n = HELD;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            HELD: begin
                if (s != cap) begin
                    cnt_n   = '0;
                    state_n = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s == cap) begin
                    state_n = HELD;
                end else if (cnt == CNT_LAST) begin
                    cap_n   = NO_KEY;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: state_n = IDLE;
        endcase

        col_n   = (state_n == HELD || state_n == RELEASE_WAIT) ? cap_n : NO_KEY;
        pulse_n = (state == PRESS_WAIT) && (state_n == HELD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cap         <= NO_KEY;
            cnt         <= '0;
            r_q         <= '1;
            col_sync    <= NO_KEY;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            cap         <= cap_n;
            cnt         <= cnt_n;
            r_q         <= r_sel;
            col_sync    <= col_n;
            press_pulse <= pulse_n;
        end
    end

    assign key_held = (col_sync != NO_KEY);

endmodule

// File: tb/tb_keypad_col_debounce.sv
// Bench for keypad_col_debounce: directed scenarios plus random stimulus against a run-length model.
module tb_keypad_col_debounce;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_raw;
    logic [3:0] r_sel;
    logic [3:0] col_sync;
    logic       key_held;
    logic       press_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: two-sample delay line, pending key with agreement count,
    // reported key with disagreement count.
    logic [3:0] mp0, mp1, m_rq, m_rep, m_pk;
    int         m_agree, m_miss;
    logic       m_pulse;

    keypad_col_debounce #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .col_raw    (col_raw),
        .r_sel      (r_sel),
        .col_sync   (col_sync),
        .key_held   (key_held),
        .press_pulse(press_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mp0 = 4'b1111; mp1 = 4'b1111; m_rq = 4'b1111;
        m_rep = 4'b0000; m_pk = 4'b0000;
        m_agree = 0; m_miss = 0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic [3:0] sv;
        logic       rowchg;
        if (reset) begin
            model_reset();
            return;
        end
        sv = ~mp1;
        mp1 = mp0;
        mp0 = col_raw;
        rowchg = (r_sel != m_rq);
        m_rq = r_sel;
        m_pulse = 1'b0;
        if (m_rep != 4'b0000) begin
            if (sv == m_rep) m_miss = 0;
            else begin
                m_miss++;
                if (m_miss == D + 1) begin m_rep = 4'b0000; m_pk = 4'b0000; end
            end
        end else if (m_pk == 4'b0000) begin
            if ($countones(sv) == 1) begin m_pk = sv; m_agree = 0; end
        end else if (sv != m_pk || rowchg) begin
            m_pk = 4'b0000;
        end else begin
            m_agree++;
            if (m_agree == D) begin m_rep = m_pk; m_pulse = 1'b1; m_miss = 0; end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    // Runs n clocks, noting the first tick col_sync is non-zero / zero and the pulse count.
    task automatic run(input int n, output int on_at, output int off_at, output int pulses);
        on_at = 0; off_at = 0; pulses = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (press_pulse) pulses++;
            if (on_at == 0 && col_sync != 4'b0000) on_at = i;
            if (off_at == 0 && col_sync == 4'b0000) off_at = i;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; col_raw = 4'b1111; r_sel = 4'b1110;
        model_reset();
        #1;
        checks++; if (col_sync !== 4'b0000) begin errors++; $display("FAIL reset_col got %b want 0000", col_sync); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got %b want 0", press_pulse); end
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++; if (col_sync !== 4'b0000) begin errors++; $display("FAIL idle_col got %b want 0000", col_sync); end
    endtask

    task automatic test_clean_press();
        int on_at, off_at, pulses;
        col_raw = 4'b1101;
        run(20, on_at, off_at, pulses);
        checks++; if (on_at != 7) begin errors++; $display("FAIL press_latency got %0d want 7", on_at); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL press_pulses got %0d want 1", pulses); end
        checks++; if (col_sync !== 4'b0010 || key_held !== 1'b1) begin
            errors++; $display("FAIL press_value got %b/%b want 0010/1", col_sync, key_held); end
        col_raw = 4'b1111;
        run(12, on_at, off_at, pulses);
        checks++; if (off_at != 7) begin errors++; $display("FAIL release_latency got %0d want 7", off_at); end
        checks++; if (col_sync !== 4'b0000 || key_held !== 1'b0) begin
            errors++; $display("FAIL release_value got %b/%b want 0000/0", col_sync, key_held); end
    endtask

    task automatic test_press_bounce();
        int on_at, off_at, p1, p2, p3;
        col_raw = 4'b1101; run(2, on_at, off_at, p1);
        col_raw = 4'b1111; run(1, on_at, off_at, p2);
        col_raw = 4'b1101; run(15, on_at, off_at, p3);
        checks++; if (on_at != 7) begin errors++; $display("FAIL bounce_latency got %0d want 7", on_at); end
        checks++; if (p1 + p2 + p3 != 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", p1 + p2 + p3); end
        col_raw = 4'b1111; run(12, on_at, off_at, p1);
    endtask

    task automatic test_release_bounce();
        int on_at, off_at, pulses, p2;
        col_raw = 4'b1101; run(12, on_at, off_at, pulses);
        col_raw = 4'b1111; run(2, on_at, off_at, pulses);
        col_raw = 4'b1101; run(12, on_at, off_at, p2);
        checks++; if (off_at != 0) begin errors++; $display("FAIL relbounce_drop got %0d want 0", off_at); end
        checks++; if (pulses + p2 != 0) begin errors++; $display("FAIL relbounce_pulses got %0d want 0", pulses + p2); end
        checks++; if (col_sync !== 4'b0010) begin errors++; $display("FAIL relbounce_col got %b want 0010", col_sync); end
        col_raw = 4'b1111; run(12, on_at, off_at, pulses);
    endtask

    task automatic test_multi_key();
        int on_at, off_at, pulses;
        col_raw = 4'b1100; run(15, on_at, off_at, pulses);
        checks++; if (on_at != 0 || pulses != 0) begin
            errors++; $display("FAIL multi_ignored got on=%0d pulses=%0d want 0/0", on_at, pulses); end
        col_raw = 4'b1110; run(12, on_at, off_at, pulses);
        checks++; if (on_at != 7) begin errors++; $display("FAIL multi_next_latency got %0d want 7", on_at); end
        checks++; if (col_sync !== 4'b0001) begin errors++; $display("FAIL multi_next_col got %b want 0001", col_sync); end
        col_raw = 4'b1111; run(12, on_at, off_at, pulses);
    endtask

    task automatic test_row_change();
        int on_at, off_at, p1, p2;
        r_sel = 4'b1110; col_raw = 4'b1101;
        run(5, on_at, off_at, p1);
        r_sel = 4'b1101;
        run(15, on_at, off_at, p2);
        checks++; if (p1 != 0) begin errors++; $display("FAIL row_abort_pulse got %0d want 0", p1); end
        checks++; if (on_at != 6) begin errors++; $display("FAIL row_restart_latency got %0d want 6", on_at); end
        checks++; if (p2 != 1) begin errors++; $display("FAIL row_restart_pulses got %0d want 1", p2); end
        col_raw = 4'b1111; run(12, on_at, off_at, p1);
        r_sel = 4'b1110; run(2, on_at, off_at, p1);
    endtask

    task automatic test_async_reset();
        int on_at, off_at, pulses;
        col_raw = 4'b1101; run(12, on_at, off_at, pulses);
        #2 reset = 1'b1;
        model_reset();
        #1;
        checks++; if (col_sync !== 4'b0000 || key_held !== 1'b0 || press_pulse !== 1'b0) begin
            errors++; $display("FAIL async_reset got %b/%b/%b want 0000/0/0", col_sync, key_held, press_pulse); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run(12, on_at, off_at, pulses);
        checks++; if (on_at != 7) begin errors++; $display("FAIL reset_repress_latency got %0d want 7", on_at); end
        checks++; if (pulses != 1) begin errors++; $display("FAIL reset_repress_pulses got %0d want 1", pulses); end
        col_raw = 4'b1111; run(12, on_at, off_at, pulses);
    endtask

    task automatic test_random();
        logic [3:0] pats [8];
        logic [3:0] rows [4];
        int         len;
        int         bad;
        pats = '{4'b1111, 4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100, 4'b0101};
        rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bad = 0;
        for (int seg = 0; seg < 250; seg++) begin
            col_raw = pats[$urandom_range(7, 0)];
            if ($urandom_range(7, 0) == 0) r_sel = rows[$urandom_range(3, 0)];
            len = ($urandom_range(3, 0) == 0) ? $urandom_range(12, 6) : $urandom_range(4, 1);
            for (int i = 0; i < len; i++) begin
                tick();
                checks++;
                if (col_sync !== m_rep || press_pulse !== m_pulse || key_held !== (m_rep != 4'b0000)) begin
                    errors++;
                    if (bad < 10) $display("FAIL random seg %0d got %b/%b/%b want %b/%b/%b", seg,
                                           col_sync, key_held, press_pulse, m_rep, m_rep != 4'b0000, m_pulse);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_multi_key();
        test_row_change();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
